// File: rtl/adaptive_multi_thresholder_pkg.sv
// Shared types and elaboration-time helpers for the adaptive multi-level thresholder.
package adaptive_multi_thresholder_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_SCAN,
    ST_PUBLISH
  } state_e;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  // Evenly spaced start-up thresholds, k = 1..levels-1.
  function automatic int def_thresh(input int k, input int pix_w, input int levels);
    return (k * (1 << pix_w)) / levels;
  endfunction

  function automatic int lvl_grey(input int lvl, input int pix_w, input int levels);
    return (lvl * ((1 << pix_w) - 1)) / (levels - 1);
  endfunction

endpackage

// File: rtl/adaptive_multi_thresholder_hist_ram.sv
// Histogram storage: simple dual-port RAM, registered read, read-first on collisions.
module hist_ram #(
  parameter int AW = 8,
  parameter int DW = 20
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/adaptive_multi_thresholder.sv
// Per-frame histogram, equal-population percentile thresholds and a 2-stage grey quantiser.
module adaptive_multi_thresholder
  import adaptive_multi_thresholder_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int LEVELS = 4,
  parameter int CNT_W  = 20
) (
  input  logic                        iClk,
  input  logic                        iRst_n,
  input  logic [PIX_W-1:0]            iGray,
  input  logic                        iValid,
  input  logic                        iFval,
  input  logic                        iFreeze,
  output logic [PIX_W-1:0]            oPixel,
  output logic [clog2(LEVELS)-1:0]    oLevel,
  output logic                        oValid,
  output logic [(LEVELS-1)*PIX_W-1:0] oThresh,
  output logic                        oDone,
  output logic                        oSkip,
  output logic                        oBusy
);

  localparam int LW = clog2(LEVELS);
  localparam int NT = LEVELS - 1;
  localparam int NB = 1 << PIX_W;
  localparam int PW = CNT_W + LW + 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  state_e                   state_q, state_d;
  logic [PIX_W:0]           cnt_q, cnt_d;
  logic                     fval_q, rise, fall, acc_hit;
  logic [CNT_W-1:0]         total_q, total_d;
  logic                     acc_vld_q, scan_vld_q;
  logic [PIX_W-1:0]         rd_addr_d, rd_addr_q;
  logic [CNT_W-1:0]         ram_rdata, base;
  logic                     we;
  logic [PIX_W-1:0]         waddr;
  logic [CNT_W-1:0]         wdata;
  logic                     wr_vld_q;
  logic [PIX_W-1:0]         wr_addr_q;
  logic [CNT_W-1:0]         wr_data_q;
  logic [CNT_W-1:0]         cum_q, cum_d, cum_nx;
  logic [CNT_W:0]           cum_sum;
  logic [NT-1:0]            got_q, got_d, hit;
  logic [NT-1:0][PIX_W-1:0] cand_q, cand_d, thresh_q, thr_nx;
  logic                     pub, done_q, skip_q, skip_d;
  logic [1:0]               vld_pipe;
  logic [NT-1:0]            gt_q, gt_d;
  logic [LW-1:0]            lvl_d, lvl_q;
  logic [PIX_W-1:0]         pix_q;
  logic [PIX_W-1:0]         lut [LEVELS];

  assign rise    = iFval & ~fval_q;
  assign fall    = ~iFval & fval_q;
  assign acc_hit = iValid & ((state_q == ST_ACCUM) | ((state_q == ST_IDLE) & rise));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    skip_d  = 1'b0;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == (PIX_W+1)'(NB - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE:  if (rise) state_d = ST_ACCUM;
      ST_ACCUM: if (fall) begin
        state_d = ST_DRAIN;
        cnt_d   = '0;
      end
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == (PIX_W+1)'(1)) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end
      end
      // One extra cycle past the last read lets the final bin reach the comparators.
      ST_SCAN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q[PIX_W]) state_d = ST_PUBLISH;
      end
      ST_PUBLISH: state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase
    if (rise && (state_q inside {ST_INIT, ST_DRAIN, ST_SCAN, ST_PUBLISH})) skip_d = 1'b1;
  end

  assign rd_addr_d = (state_q == ST_SCAN) ? cnt_q[PIX_W-1:0] : iGray;

  hist_ram #(.AW(PIX_W), .DW(CNT_W)) u_ram (
    .clk_i   (iClk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .raddr_i (rd_addr_d),
    .rdata_o (ram_rdata)
  );

  // The RAM misses the write landing on the same edge as the read; take it from the write copy.
  assign base = (wr_vld_q && (wr_addr_q == rd_addr_q)) ? wr_data_q : ram_rdata;

  always_comb begin
    we    = 1'b0;
    waddr = rd_addr_q;
    wdata = '0;
    if (state_q == ST_INIT) begin
      we    = 1'b1;
      waddr = cnt_q[PIX_W-1:0];
    end else if (acc_vld_q) begin
      we    = 1'b1;
      wdata = (base == CMAX) ? base : base + 1'b1;
    end else if (scan_vld_q) begin
      we    = 1'b1;
    end
  end

  always_comb begin
    total_d = total_q;
    if ((state_q == ST_IDLE) && rise) total_d = {{(CNT_W-1){1'b0}}, iValid};
    else if (acc_hit && (total_q != CMAX)) total_d = total_q + 1'b1;
  end

  assign cum_sum = {1'b0, cum_q} + {1'b0, base};
  assign cum_nx  = cum_sum[CNT_W] ? CMAX : cum_sum[CNT_W-1:0];

  for (genvar g = 0; g < NT; g++) begin : g_cmp
    assign hit[g] = (PW'(cum_nx) * PW'(LEVELS)) >= (PW'(total_q) * PW'(g + 1));
  end

  always_comb begin
    cum_d  = cum_q;
    got_d  = got_q;
    cand_d = cand_q;
    if (state_q == ST_DRAIN) begin
      cum_d = '0;
      got_d = '0;
      for (int k = 0; k < NT; k++) cand_d[k] = '1;
    end else if (scan_vld_q) begin
      cum_d = cum_nx;
      for (int k = 0; k < NT; k++) begin
        if (!got_q[k] && hit[k]) begin
          got_d[k]  = 1'b1;
          cand_d[k] = rd_addr_q;
        end
      end
    end
  end

  assign pub    = (state_q == ST_PUBLISH) && (total_q != '0) && !iFreeze;
  assign thr_nx = pub ? cand_q : thresh_q;

  for (genvar g = 0; g < LEVELS; g++) begin : g_lut
    assign lut[g] = PIX_W'(lvl_grey(g, PIX_W, LEVELS));
  end

  always_comb begin
    for (int k = 0; k < NT; k++) gt_d[k] = iGray > thr_nx[k];
    lvl_d = '0;
    for (int k = 0; k < NT; k++) lvl_d = lvl_d + LW'(gt_q[k]);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      fval_q     <= 1'b0;
      total_q    <= '0;
      acc_vld_q  <= 1'b0;
      scan_vld_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_vld_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cum_q      <= '0;
      got_q      <= '0;
      for (int k = 0; k < NT; k++) begin
        cand_q[k]   <= '1;
        thresh_q[k] <= PIX_W'(def_thresh(k + 1, PIX_W, LEVELS));
      end
      done_q     <= 1'b0;
      skip_q     <= 1'b0;
      vld_pipe   <= '0;
      gt_q       <= '0;
      lvl_q      <= '0;
      pix_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fval_q     <= iFval;
      total_q    <= total_d;
      acc_vld_q  <= acc_hit;
      scan_vld_q <= (state_q == ST_SCAN) && !cnt_q[PIX_W];
      rd_addr_q  <= rd_addr_d;
      wr_vld_q   <= we;
      wr_addr_q  <= waddr;
      wr_data_q  <= wdata;
      cum_q      <= cum_d;
      got_q      <= got_d;
      cand_q     <= cand_d;
      thresh_q   <= thr_nx;
      done_q     <= (state_q == ST_PUBLISH);
      skip_q     <= skip_d;
      vld_pipe   <= {vld_pipe[0], iValid};
      gt_q       <= gt_d;
      lvl_q      <= lvl_d;
      pix_q      <= lut[lvl_d];
    end
  end

  assign oThresh = thresh_q;
  assign oPixel  = pix_q;
  assign oLevel  = lvl_q;
  assign oValid  = vld_pipe[1];
  assign oDone   = done_q;
  assign oSkip   = skip_q;
  assign oBusy   = !((state_q == ST_IDLE) || (state_q == ST_ACCUM));

endmodule

// File: tb/tb_adaptive_multi_thresholder.sv
// Randomised scoreboard bench: percentile model from sorted frame pixels, quantiser checked per pixel.
module tb_adaptive_multi_thresholder;
  localparam int PIX_W  = 8;
  localparam int LEVELS = 4;
  localparam int CNT_W  = 20;
  localparam int NT     = LEVELS - 1;

  logic                      iClk = 1'b0;
  logic                      iRst_n;
  logic [PIX_W-1:0]          iGray;
  logic                      iValid, iFval, iFreeze;
  logic [PIX_W-1:0]          oPixel;
  logic [1:0]                oLevel;
  logic                      oValid, oDone, oSkip, oBusy;
  logic [NT*PIX_W-1:0]       oThresh;

  adaptive_multi_thresholder #(.PIX_W(PIX_W), .LEVELS(LEVELS), .CNT_W(CNT_W)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iGray(iGray), .iValid(iValid), .iFval(iFval),
    .iFreeze(iFreeze), .oPixel(oPixel), .oLevel(oLevel), .oValid(oValid),
    .oThresh(oThresh), .oDone(oDone), .oSkip(oSkip), .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  typedef struct { int lvl; int pix; int stamp; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int   mthr[NT];
  int   cyc = 0, n_chk = 0, n_fail = 0, done_cnt = 0, skip_cnt = 0;

  always @(posedge iClk) cyc++;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int k = 1; k < LEVELS; k++) mthr[k-1] = k * 256 / LEVELS;
  endfunction

  // Threshold k is the ceil(k*N/LEVELS)-th smallest pixel of the frame.
  function automatic void model_update(input int px[$]);
    int s[$];
    int n;
    s = px;
    n = s.size();
    if (n == 0) return;
    s.sort();
    for (int k = 1; k < LEVELS; k++) mthr[k-1] = s[(k * n + LEVELS - 1) / LEVELS - 1];
  endfunction

  function automatic void push(input int g);
    int l;
    l = 0;
    for (int k = 0; k < NT; k++) if (g > mthr[k]) l++;
    sbq.push_back('{l, l * 255 / (LEVELS - 1), cyc});
  endfunction

  always @(negedge iClk) begin
    if (iRst_n) begin
      if (oValid) begin
        if (sbq.size() == 0) check("unexpected_ovalid", 1, 0);
        else begin
          mon_e = sbq.pop_front();
          check("olevel", int'(oLevel), mon_e.lvl);
          check("opixel", int'(oPixel), mon_e.pix);
          check("latency", cyc - mon_e.stamp, 2);
        end
      end
      if (oDone) done_cnt++;
      if (oSkip) skip_cnt++;
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic send(input int g);
    tick();
    iGray = PIX_W'(g);
    iValid = 1'b1;
    push(g);
  endtask

  task automatic run_frame(input int px[$], input bit gaps);
    tick();
    iFval = 1'b1;
    for (int i = 0; i < px.size(); i++) begin
      if (i > 0) begin
        tick();
        if (gaps) while ($urandom_range(0, 3) == 0) begin
          iValid = 1'b0;
          tick();
        end
      end
      iGray = PIX_W'(px[i]);
      iValid = 1'b1;
      push(px[i]);
    end
    tick();
    iValid = 1'b0;
    iFval = 1'b0;
  endtask

  task automatic wait_done(output int n);
    tick();
    n = 0;
    do begin
      tick();
      n++;
    end while (!oDone && n < 400);
    if (!oDone) check("done_timeout", 0, 1);
  endtask

  task automatic check_thresh(input string nm);
    for (int k = 0; k < NT; k++)
      check($sformatf("%s_t%0d", nm, k + 1), int'(oThresh[k*PIX_W +: PIX_W]), mthr[k]);
  endtask

  task automatic run_init(input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 10) begin
        iGray = 8'd100;
        iValid = 1'b1;
        push(100);
      end else iValid = 1'b0;
    end while (oBusy && n < 1000);
    check(nm, n, 256);
  endtask

  function automatic void perm(output int q[$]);
    int t, j;
    q = {};
    for (int i = 0; i < 256; i++) q.push_back(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = q[i]; q[i] = q[j]; q[j] = t;
    end
  endfunction

  initial begin
    int px[$];
    int n, s0;
    int bnd[$];
    iRst_n = 1'b0; iFval = 1'b0; iValid = 1'b0; iGray = '0; iFreeze = 1'b0;
    model_reset();
    repeat (3) tick();
    check_thresh("reset");
    check("reset_busy", int'(oBusy), 1);
    check("reset_valid", int'(oValid), 0);
    check("reset_done", int'(oDone), 0);
    check("reset_skip", int'(oSkip), 0);
    check("reset_level", int'(oLevel), 0);
    check("reset_pixel", int'(oPixel), 0);
    iRst_n = 1'b1;
    run_init("init_cycles");

    bnd = '{0, 64, 65, 128, 129, 192, 193, 255};
    foreach (bnd[i]) send(bnd[i]);
    tick(); iValid = 1'b0;
    repeat (4) tick();

    perm(px);
    run_frame(px, 1'b0);
    wait_done(n);
    check("done_latency", n, 260);
    model_update(px);
    check_thresh("uniform");
    check("uniform_t1_const", int'(oThresh[7:0]), 63);

    px = {};
    for (int i = 0; i < 1000; i++) px.push_back(100);
    run_frame(px, 1'b0);
    wait_done(n);
    model_update(px);
    check_thresh("flat100");

    perm(px);
    run_frame(px, 1'b1);
    wait_done(n);
    check("done_latency_gaps", n, 260);
    model_update(px);
    check_thresh("uniform_after_flat");

    bnd = '{63, 64, 127, 128, 200};
    foreach (bnd[i]) send(bnd[i]);
    for (int i = 0; i < 40; i++) send($urandom_range(0, 255));
    tick(); iValid = 1'b0;
    repeat (4) tick();

    px = {};
    s0 = done_cnt;
    run_frame(px, 1'b0);
    wait_done(n);
    check("empty_done_latency", n, 260);
    check_thresh("empty");

    for (int i = 0; i < 200; i++) px.push_back($urandom_range(0, 255));
    iFreeze = 1'b1;
    run_frame(px, 1'b0);
    wait_done(n);
    iFreeze = 1'b0;
    check_thresh("freeze");
    repeat (3) tick();
    check("done_pulses", done_cnt - s0, 2);

    px = {};
    for (int i = 0; i < 300; i++) px.push_back($urandom_range(0, 255));
    run_frame(px, 1'b0);
    repeat (20) tick();
    s0 = skip_cnt;
    bnd = {};
    for (int i = 0; i < 30; i++) bnd.push_back(5);
    run_frame(bnd, 1'b0);
    check("busy_in_scan", int'(oBusy), 1);
    repeat (3) tick();
    check("skip_pulse", skip_cnt - s0, 1);
    n = 0;
    while (!oDone && n < 400) begin tick(); n++; end
    check("skip_done_seen", int'(oDone), 1);
    model_update(px);
    check_thresh("pre_skip_frame");
    px = {};
    for (int i = 0; i < 300; i++) px.push_back($urandom_range(0, 255));
    repeat (3) tick();
    run_frame(px, 1'b0);
    wait_done(n);
    model_update(px);
    check_thresh("post_skip_frame");

    tick();
    iFval = 1'b1;
    for (int i = 0; i < 50; i++) send(7);
    tick(); iValid = 1'b0;
    repeat (4) tick();
    iRst_n = 1'b0;
    #1;
    model_reset();
    sbq.delete();
    check_thresh("midframe_reset");
    check("midframe_reset_busy", int'(oBusy), 1);
    tick();
    iFval = 1'b0;
    tick();
    iRst_n = 1'b1;
    run_init("reinit_cycles");
    repeat (4) tick();
    perm(px);
    run_frame(px, 1'b0);
    wait_done(n);
    check("final_done_latency", n, 260);
    model_update(px);
    check_thresh("after_reinit");

    repeat (5) tick();
    check("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adaptive_multi_thresholder.md
# adaptive_multi_thresholder

Parametrised successor to the fixed 25/50/75-percentile thresholding path. It accumulates a per-frame grey-level histogram and derives LEVELS-1 equal-population percentile thresholds from that histogram's cumulative sum. It then quantises the grey pixel stream into LEVELS output levels. It sits after the RGB-to-grey stage and feeds the display arbitrator. Thresholds computed from frame N apply from frame N+1 onward.

## Interface
- PIX_W, 8: grey pixel width; the histogram has 2^PIX_W bins.
- LEVELS, 4: number of output levels (2..16); there are LEVELS-1 thresholds.
- CNT_W, 20: histogram bin, cumulative sum and total-pixel counter width.
- iClk  in  1  pixel clock.
- iRst_n  in  1  asynchronous, active-low reset.
- iGray  in  PIX_W  grey pixel.
- iValid  in  1  iGray qualifier.
- iFval  in  1  frame valid; a rising edge starts a frame and a falling edge ends it.
- iFreeze  in  1  when high, computed thresholds are not published.
- oPixel  out  PIX_W  quantised grey value.
- oLevel  out  clog2(LEVELS)  quantisation level index.
- oValid  out  1  qualifier for oPixel and oLevel.
- oThresh  out  (LEVELS-1)*PIX_W  active thresholds; threshold k occupies slice k-1 (LSB slice is k=1).
- oDone  out  1  one-cycle pulse at the end of each statistics pass.
- oSkip  out  1  one-cycle pulse when a frame starts while the block is busy.
- oBusy  out  1  high in every state except IDLE and ACCUM.

## Operation
- FSM states: INIT → IDLE → ACCUM → DRAIN → SCAN → PUBLISH → IDLE.
- INIT
  - Writes zero to all 2^PIX_W bins, one bin per cycle.
  - Entered on reset; lasts 2^PIX_W cycles.
- IDLE
  - A rising edge of iFval enters ACCUM and clears the total counter.
- ACCUM
  - Each iValid pixel increments hist[iGray] and total.
  - Both saturate at 2^CNT_W-1.
  - The read-modify-write path forwards in-flight updates, so back-to-back identical bins count exactly.
  - A falling edge of iFval enters DRAIN.
- DRAIN
  - Lasts 2 cycles to flush the read-modify-write pipeline.
- SCAN
  - Reads bins 0..2^PIX_W-1 in order, one per cycle.
  - Accumulates cum and zero-writes each bin after reading it. This makes SCAN the clear for the next frame.
  - For each k in 1..LEVELS-1, captures cand[k] = the first bin b where cum(b)*LEVELS >= k*total.
  - Products are evaluated at CNT_W+clog2(LEVELS)+1 bits with no truncation.
  - A cand[k] never captured stays at 2^PIX_W-1.
- PUBLISH
  - Lasts one cycle, then returns to IDLE.
  - Copies all cand into oThresh atomically when total != 0 and iFreeze is low; otherwise oThresh is unchanged.
  - oDone pulses in this cycle regardless of the update decision.
- A rising edge of iFval in INIT, DRAIN, SCAN or PUBLISH pulses oSkip. That frame is not accumulated; the next rising edge seen in IDLE is accumulated.
- Quantiser
  - Runs in every state.
  - oLevel = the number of thresholds t with iGray > t.
  - oPixel = oLevel*(2^PIX_W-1)/(LEVELS-1), taken from a constant table rounded down.
- Monotonicity is guaranteed by construction: thresh[k] <= thresh[k+1].

## Timing
- Reset values:
  - oThresh[k] = k*2^PIX_W/LEVELS (for PIX_W=8, LEVELS=4: 64, 128, 192).
  - oPixel, oLevel, oValid, oDone and oSkip are 0.
  - oBusy is 1, and the FSM is in INIT.
- Quantiser latency is 2 cycles, iValid→oValid:
  - Stage 1 registers the comparisons.
  - Stage 2 registers the encode and table lookup.
- A bubble-free stream produces a bubble-free output.
- The statistics pass takes 2 + 2^PIX_W + 1 (RAM read latency) + 1 cycles from the iFval falling edge to oDone; that is 260 cycles at PIX_W=8.
- oThresh changes on the same edge that raises oDone. Pixels entering stage 1 on that edge use the new thresholds.
- iFval edges are detected against a registered copy, so a rising edge is seen one cycle late. A pixel whose iValid coincides with that registered rising edge is counted.
- Reset asserted mid-frame aborts the frame and re-enters INIT; oThresh returns to its defaults.

## Structure
- A shared package holds:
  - the FSM state enum;
  - the clog2 function;
  - the default-threshold and level-to-grey table generator functions.
- Sub-module hist_ram: simple dual-port RAM, 2^PIX_W x CNT_W, with registered 1-cycle read. It has no reset; INIT provides the clear.
- The top level holds the FSM, the read-modify-write/forwarding pipeline, the scan comparators (generate loop over k) and the quantiser.

## Test plan
- Reset, then release → oThresh = {192,128,64}; oBusy falls after 256 cycles; a pixel value of 100 gives oLevel=1, oPixel=85, 2 cycles later.
- Frame of 256 pixels, values 0..255 once each → oDone 260 cycles after the falling edge; oThresh = {191,127,63}.
- Frame of 1000 back-to-back pixels, all 100 → every threshold = 100; the next frame, uniform as in the previous scenario, gives {191,127,63}, proving the scan clear worked.
- Thresholds {191,127,63}, pixels 63, 64, 127, 128, 200 → oLevel 0,1,1,2,3 and oPixel 0,85,85,170,255 at latency 2.
- Empty frame (iFval pulse, no iValid), and separately a uniform frame with iFreeze=1 → oDone pulses; oThresh unchanged.
- iFval rising during SCAN → oSkip pulse, no accumulation, stats from the following frame; reset asserted mid-ACCUM → defaults restored and INIT rerun.
